// File: rtl/elevator_call_scheduler_pkg.sv
// Shared elevator definitions used by the call scheduler and its floor picker.
//   state_e    : scheduler FSM states (IDLE, RUN, DOOR)
//   DIR_UP/DOWN: scan direction encoding carried on the dir output
//   FLOOR_W    : width of a floor number
//   NUM_FLOORS : number of served floors
package elevator_call_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DOOR = 2'd2
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int FLOOR_W    = 2;
  localparam int NUM_FLOORS = 4;

endpackage

// File: rtl/elevator_call_scheduler_floor_picker.sv
// Combinational search of the pending-call vector relative to the car.
// Ports:
//   pending_i     : latched outstanding calls, one bit per floor
//   cur_floor_i   : current car floor
//   above_o       : lowest pending floor strictly above the car
//   above_vld_o   : above_o is meaningful
//   below_o       : highest pending floor strictly below the car
//   below_vld_o   : below_o is meaningful
module elevator_call_scheduler_floor_picker
  import elevator_call_scheduler_pkg::*;
(
  input  logic [NUM_FLOORS-1:0] pending_i,
  input  logic [FLOOR_W-1:0]    cur_floor_i,
  output logic [FLOOR_W-1:0]    above_o,
  output logic                  above_vld_o,
  output logic [FLOOR_W-1:0]    below_o,
  output logic                  below_vld_o
);

  // Scanning from the far end lets the nearest match overwrite earlier ones.
  always_comb begin
    above_o     = '0;
    above_vld_o = 1'b0;
    below_o     = '0;
    below_vld_o = 1'b0;
    for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
      if (pending_i[f] && (f > int'(cur_floor_i))) begin
        above_o     = FLOOR_W'(f);
        above_vld_o = 1'b1;
      end
    end
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (pending_i[f] && (f < int'(cur_floor_i))) begin
        below_o     = FLOOR_W'(f);
        below_vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_call_scheduler.sv
// SCAN call scheduler for a four-floor elevator. Latches call buttons every
// clk, picks the next destination on each step tick, and times the door dwell.
// Ports:
//   clk          : system clock
//   rst          : asynchronous active-low reset
//   tick         : one-cycle step strobe; evaluation happens only on ticks
//   call_req     : call buttons, one bit per floor
//   cur_floor    : car position reported by the elevator core
//   target       : destination floor for the elevator core
//   hold         : 1 = car must stay put
//   door_open    : door open indicator
//   dir          : scan direction (1 = up)
//   pending      : latched outstanding calls
//   busy         : scheduler is not idle
//   served_count : saturating count of served calls
module elevator_call_scheduler
  import elevator_call_scheduler_pkg::*;
#(
  parameter int DOOR_TICKS = 3,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]    cur_floor,
  output logic [FLOOR_W-1:0]    target,
  output logic                  hold,
  output logic                  door_open,
  output logic                  dir,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy,
  output logic [CNT_W-1:0]      served_count
);

  localparam logic [3:0] DOOR_LOAD = 4'(DOOR_TICKS);

  state_e                  state_q;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic [FLOOR_W-1:0]      target_q;
  logic                    hold_q, door_open_q, dir_q, busy_q;
  logic [CNT_W-1:0]        served_q;
  logic [3:0]              timer_q;

  logic [FLOOR_W-1:0]      above, below;
  logic                    above_vld, below_vld;
  logic [NUM_FLOORS-1:0]   cur_onehot;
  logic                    in_door, reload, door_done, eval, stop_here;
  logic                    go_up, go_down;

  elevator_call_scheduler_floor_picker u_picker (
    .pending_i   (pending_q),
    .cur_floor_i (cur_floor),
    .above_o     (above),
    .above_vld_o (above_vld),
    .below_o     (below),
    .below_vld_o (below_vld)
  );

  assign cur_onehot = NUM_FLOORS'(1) << cur_floor;
  assign in_door    = (state_q == ST_DOOR);
  // A call for the floor the door is open at just keeps the door open longer.
  assign reload     = in_door && call_req[cur_floor];
  assign door_done  = in_door && tick && !reload && (timer_q <= 4'd1);
  assign eval       = (tick && !in_door) || door_done;
  assign stop_here  = eval && pending_q[cur_floor];

  // Keep going the current way while calls remain ahead, else reverse.
  assign go_up   = above_vld && ((dir_q == DIR_UP) || !below_vld);
  assign go_down = below_vld && !go_up;

  always_comb begin
    pending_d = pending_q | (in_door ? (call_req & ~cur_onehot) : call_req);
    // Clearing the served floor wins over a same-cycle press of that button.
    if (stop_here) pending_d = pending_d & ~cur_onehot;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      target_q    <= '0;
      hold_q      <= 1'b1;
      door_open_q <= 1'b0;
      dir_q       <= DIR_UP;
      busy_q      <= 1'b0;
      served_q    <= '0;
      timer_q     <= '0;
    end else begin
      pending_q <= pending_d;

      if (reload) begin
        timer_q <= DOOR_LOAD;
      end else if (in_door && tick) begin
        timer_q <= timer_q - 4'd1;
      end

      if (door_done) door_open_q <= 1'b0;

      if (eval) begin
        if (pending_q[cur_floor]) begin
          state_q     <= ST_DOOR;
          hold_q      <= 1'b1;
          door_open_q <= 1'b1;
          busy_q      <= 1'b1;
          timer_q     <= DOOR_LOAD;
          if (served_q != '1) served_q <= served_q + CNT_W'(1);
        end else if (go_up) begin
          state_q  <= ST_RUN;
          dir_q    <= DIR_UP;
          target_q <= above;
          hold_q   <= 1'b0;
          busy_q   <= 1'b1;
        end else if (go_down) begin
          state_q  <= ST_RUN;
          dir_q    <= DIR_DOWN;
          target_q <= below;
          hold_q   <= 1'b0;
          busy_q   <= 1'b1;
        end else begin
          state_q <= ST_IDLE;
          hold_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      end
    end
  end

  assign target       = target_q;
  assign hold         = hold_q;
  assign door_open    = door_open_q;
  assign dir          = dir_q;
  assign pending      = pending_q;
  assign busy         = busy_q;
  assign served_count = served_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
module tb_elevator_call_scheduler;

  localparam int DT = 3;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic [3:0]    call_req;
  logic [1:0]    cur_floor;
  logic [1:0]    target;
  logic          hold, door_open, dir, busy;
  logic [3:0]    pending;
  logic [CW-1:0] served_count;

  int errors = 0;
  int checks = 0;

  // Reference model state: 0 = idle, 1 = running, 2 = door open
  int     m_state;
  bit [3:0] m_pend;
  int     m_target, m_timer, m_served;
  bit     m_hold, m_door, m_dir;

  always #5 clk = ~clk;

  elevator_call_scheduler #(.DOOR_TICKS(DT), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .call_req     (call_req),
    .cur_floor    (cur_floor),
    .target       (target),
    .hold         (hold),
    .door_open    (door_open),
    .dir          (dir),
    .pending      (pending),
    .busy         (busy),
    .served_count (served_count)
  );

  task automatic model_reset();
    m_state = 0; m_pend = '0; m_target = 0; m_timer = 0; m_served = 0;
    m_hold = 1; m_door = 0; m_dir = 1;
  endtask

  // One clk of the scheduling rules, applied to the pre-edge state.
  task automatic model_step(input bit tk, input bit [3:0] cr, input int cur);
    bit [3:0] np;
    bit       ev;
    int       above, below;
    np = m_pend;
    ev = 0;
    for (int f = 0; f < 4; f++)
      if (cr[f] && !(m_state == 2 && f == cur)) np[f] = 1;
    if (m_state == 2) begin
      if (cr[cur]) m_timer = DT;
      else if (tk) begin
        m_timer = m_timer - 1;
        if (m_timer == 0) begin m_door = 0; ev = 1; end
      end
    end else if (tk) ev = 1;
    if (ev) begin
      above = -1; below = -1;
      for (int f = 3; f > cur; f--) if (m_pend[f]) above = f;
      for (int f = 0; f < cur; f++) if (m_pend[f]) below = f;
      if (m_pend[cur]) begin
        m_state = 2; m_hold = 1; m_door = 1; m_timer = DT; np[cur] = 0;
        if (m_served < (1 << CW) - 1) m_served++;
      end else if (above < 0 && below < 0) begin
        m_state = 0; m_hold = 1;
      end else begin
        m_state = 1; m_hold = 0;
        if ((m_dir && above >= 0) || below < 0) begin m_dir = 1; m_target = above; end
        else begin m_dir = 0; m_target = below; end
      end
    end
    m_pend = np;
  endtask

  task automatic cyc(input bit tk, input bit [3:0] cr);
    @(negedge clk);
    tick = tk; call_req = cr;
    @(posedge clk);
    model_step(tk, cr, int'(cur_floor));
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0; tick = 0; call_req = '0;
    @(negedge clk);
    model_reset();
    #1;
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0; tick = 0; call_req = '0; cur_floor = '0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({target, hold, door_open, dir, pending, busy, served_count} !== {2'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_values: got t=%0d h=%0b d=%0b dir=%0b p=%b b=%0b s=%0d want t=0 h=1 d=0 dir=1 p=0000 b=0 s=0",
               target, hold, door_open, dir, pending, busy, served_count);
    end
    rst = 1;
  endtask

  task automatic test_call_to_floor2();
    do_reset();
    cur_floor = 2'd0;
    cyc(0, 4'b0100);
    checks++;
    if (pending !== 4'b0100) begin errors++; $display("FAIL c2_pending_latch: got %b want 0100", pending); end
    cyc(1, 4'b0000);
    checks++;
    if ({target, hold, dir, busy} !== {2'd2, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL c2_dispatch: got t=%0d h=%0b dir=%0b b=%0b want t=2 h=0 dir=1 b=1", target, hold, dir, busy);
    end
    cur_floor = 2'd2;
    cyc(1, 4'b0000);
    checks++;
    if ({door_open, hold, pending, served_count} !== {1'b1, 1'b1, 4'b0000, 8'd1}) begin
      errors++;
      $display("FAIL c2_arrive: got d=%0b h=%0b p=%b s=%0d want d=1 h=1 p=0000 s=1", door_open, hold, pending, served_count);
    end
    cyc(1, 4'b0000);
    cyc(1, 4'b0000);
    checks++;
    if (door_open !== 1'b1) begin errors++; $display("FAIL c2_dwell: got door_open=%0b want 1", door_open); end
    cyc(1, 4'b0000);
    checks++;
    if ({door_open, hold, busy} !== {1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL c2_close_idle: got d=%0b h=%0b b=%0b want d=0 h=1 b=0", door_open, hold, busy);
    end
  endtask

  task automatic test_call_at_current();
    int s0;
    s0 = m_served;
    cur_floor = 2'd1;
    cyc(0, 4'b0010);
    cyc(1, 4'b0000);
    checks++;
    if ({door_open, hold, busy, served_count} !== {1'b1, 1'b1, 1'b1, 8'(s0 + 1)}) begin
      errors++;
      $display("FAIL cur_floor_door: got d=%0b h=%0b b=%0b s=%0d want d=1 h=1 b=1 s=%0d",
               door_open, hold, busy, served_count, s0 + 1);
    end
    for (int i = 0; i < DT; i++) begin
      cyc(1, 4'b0000);
      checks++;
      if (hold !== 1'b1) begin errors++; $display("FAIL cur_floor_hold: got %0b want 1 at tick %0d", hold, i); end
    end
  endtask

  task automatic test_scan_order();
    do_reset();
    cur_floor = 2'd1;
    cyc(0, 4'b1001);
    cyc(1, 4'b0000);
    checks++;
    if ({target, dir} !== {2'd3, 1'b1}) begin
      errors++; $display("FAIL scan_first: got t=%0d dir=%0b want t=3 dir=1", target, dir);
    end
    cur_floor = 2'd3;
    cyc(1, 4'b0000);
    for (int i = 0; i < DT; i++) cyc(1, 4'b0000);
    checks++;
    if ({target, dir, hold} !== {2'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL scan_reverse: got t=%0d dir=%0b h=%0b want t=0 dir=0 h=0", target, dir, hold);
    end
    cur_floor = 2'd0;
    cyc(1, 4'b0000);
    checks++;
    if ({door_open, served_count} !== {1'b1, 8'd2}) begin
      errors++; $display("FAIL scan_served: got d=%0b s=%0d want d=1 s=2", door_open, served_count);
    end
    for (int i = 0; i < DT; i++) cyc(1, 4'b0000);
  endtask

  task automatic test_enroute();
    do_reset();
    cur_floor = 2'd0;
    cyc(0, 4'b1000);
    cyc(1, 4'b0000);
    checks++;
    if (target !== 2'd3) begin errors++; $display("FAIL enroute_initial: got t=%0d want 3", target); end
    cur_floor = 2'd1;
    cyc(0, 4'b0100);
    cyc(1, 4'b0000);
    checks++;
    if ({target, hold} !== {2'd2, 1'b0}) begin
      errors++; $display("FAIL enroute_pickup: got t=%0d h=%0b want t=2 h=0", target, hold);
    end
    cur_floor = 2'd2;
    cyc(1, 4'b0000);
    checks++;
    if ({door_open, pending} !== {1'b1, 4'b1000}) begin
      errors++; $display("FAIL enroute_stop: got d=%0b p=%b want d=1 p=1000", door_open, pending);
    end
    for (int i = 0; i < DT; i++) cyc(1, 4'b0000);
    checks++;
    if ({target, hold, door_open} !== {2'd3, 1'b0, 1'b0}) begin
      errors++; $display("FAIL enroute_resume: got t=%0d h=%0b d=%0b want t=3 h=0 d=0", target, hold, door_open);
    end
  endtask

  task automatic test_door_reload();
    do_reset();
    cur_floor = 2'd1;
    cyc(0, 4'b0010);
    cyc(1, 4'b0000);
    cyc(1, 4'b0000);
    cyc(1, 4'b0000);
    cyc(0, 4'b0010);
    checks++;
    if ({door_open, pending[1]} !== {1'b1, 1'b0}) begin
      errors++; $display("FAIL reload_latch: got d=%0b p1=%0b want d=1 p1=0", door_open, pending[1]);
    end
    cyc(1, 4'b0000);
    cyc(1, 4'b0000);
    checks++;
    if (door_open !== 1'b1) begin errors++; $display("FAIL reload_hold: got d=%0b want 1", door_open); end
    cyc(1, 4'b0000);
    checks++;
    if ({door_open, pending} !== {1'b0, 4'b0000}) begin
      errors++; $display("FAIL reload_close: got d=%0b p=%b want d=0 p=0000", door_open, pending);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cur_floor = 2'd0;
    cyc(0, 4'b1000);
    cyc(1, 4'b0000);
    cyc(0, 4'b0100);
    rst = 0;
    #1;
    checks++;
    if ({target, hold, door_open, dir, pending, busy, served_count} !== {2'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL async_reset: got t=%0d h=%0b d=%0b dir=%0b p=%b b=%0b s=%0d want t=0 h=1 d=0 dir=1 p=0000 b=0 s=0",
               target, hold, door_open, dir, pending, busy, served_count);
    end
    model_reset();
    tick = 0; call_req = '0;
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_saturation();
    do_reset();
    cur_floor = 2'd0;
    for (int n = 1; n <= 256; n++) begin
      cyc(0, 4'b0001);
      cyc(1, 4'b0000);
      for (int i = 0; i < DT; i++) cyc(1, 4'b0000);
      if (n == 255 || n == 256) begin
        checks++;
        if (served_count !== 8'd255) begin
          errors++; $display("FAIL saturate_%0d: got %0d want 255", n, served_count);
        end
      end
    end
  endtask

  task automatic test_random();
    bit       tk, move;
    bit [3:0] cr;
    int       tgt, cur;
    do_reset();
    cur_floor = 2'd0;
    for (int n = 0; n < 3000; n++) begin
      tk   = ($urandom_range(0, 2) == 0);
      cr   = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
      move = tk && !m_hold;
      tgt  = m_target;
      cyc(tk, cr);
      if (move) begin
        cur = int'(cur_floor);
        if (tgt > cur) cur_floor = 2'(cur + 1);
        else if (tgt < cur) cur_floor = 2'(cur - 1);
      end
      checks++;
      if ({target, hold, door_open, dir, pending, busy, served_count} !==
          {2'(m_target), m_hold, m_door, m_dir, m_pend, (m_state != 0), 8'(m_served)}) begin
        errors++;
        $display("FAIL random_cycle%0d: got t=%0d h=%0b d=%0b dir=%0b p=%b b=%0b s=%0d want t=%0d h=%0b d=%0b dir=%0b p=%b b=%0b s=%0d",
                 n, target, hold, door_open, dir, pending, busy, served_count,
                 m_target, m_hold, m_door, m_dir, m_pend, (m_state != 0), m_served);
      end
    end
  endtask

  initial begin
    rst = 0; tick = 0; call_req = '0; cur_floor = '0;
    test_reset();
    test_call_to_floor2();
    test_call_at_current();
    test_scan_order();
    test_enroute();
    test_door_reload();
    test_async_reset();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
